// File: rtl/measure_div_sched.sv
// rtl/measure_div_sched.sv - centroid divider: one shared restoring divider computes x_sum/count then y_sum/count
// Results are saturated to INPUT_WIDTH bits; a zero count short-circuits to DONE with no_object set.
module measure_div_sched #(
   parameter int INPUT_WIDTH = 11,
   parameter int SUM_WIDTH   = 27,
   parameter int COUNT_WIDTH = 19
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   enable,
   input  logic                   frame_done,
   input  logic [SUM_WIDTH-1:0]   x_sum,
   input  logic [SUM_WIDTH-1:0]   y_sum,
   input  logic [COUNT_WIDTH-1:0] total_count,
   output logic [INPUT_WIDTH-1:0] x_position,
   output logic [INPUT_WIDTH-1:0] y_position,
   output logic                   valid_position,
   output logic                   no_object,
   output logic                   busy,
   output logic                   overrun
);

   localparam int CNT_W = $clog2(SUM_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SUM_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

   state_t                 state_q, state_d;
   logic [SUM_WIDTH-1:0]   dvd_q, dvd_d;
   logic [SUM_WIDTH-1:0]   ysum_q, ysum_d;
   logic [COUNT_WIDTH-1:0] div_q, div_d;
   logic [COUNT_WIDTH-1:0] rem_q, rem_d;
   logic [SUM_WIDTH-1:0]   quot_q, quot_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [INPUT_WIDTH-1:0] xq_q, xq_d;
   logic [INPUT_WIDTH-1:0] xpos_q, xpos_d;
   logic [INPUT_WIDTH-1:0] ypos_q, ypos_d;
   logic                   valid_q, valid_d;
   logic                   noobj_q, noobj_d;
   logic                   ovr_q, ovr_d;

   logic [COUNT_WIDTH:0]   trial;
   logic [COUNT_WIDTH:0]   diff;
   logic                   qbit;
   logic [COUNT_WIDTH-1:0] rem_next;
   logic [SUM_WIDTH-1:0]   quot_next;

   function automatic logic [INPUT_WIDTH-1:0] sat(input logic [SUM_WIDTH-1:0] q);
      if (|q[SUM_WIDTH-1:INPUT_WIDTH]) return '1;
      return q[INPUT_WIDTH-1:0];
   endfunction

   // One restoring step: shift the next dividend bit into the partial remainder.
   always_comb begin
      trial     = {rem_q, dvd_q[SUM_WIDTH-1]};
      diff      = trial - {1'b0, div_q};
      qbit      = (trial >= {1'b0, div_q});
      rem_next  = qbit ? diff[COUNT_WIDTH-1:0] : trial[COUNT_WIDTH-1:0];
      quot_next = {quot_q[SUM_WIDTH-2:0], qbit};
   end

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      ysum_d  = ysum_q;
      div_d   = div_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      cnt_d   = cnt_q;
      xq_d    = xq_q;
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      valid_d = 1'b0;
      noobj_d = noobj_q;
      ovr_d   = ovr_q;
      if (!enable) begin
         state_d = IDLE;
         xpos_d  = '0;
         ypos_d  = '0;
         noobj_d = 1'b0;
         ovr_d   = 1'b0;
      end else begin
         if (frame_done && state_q != IDLE) ovr_d = 1'b1;
         case (state_q)
            IDLE: begin
               if (frame_done) begin
                  dvd_d   = x_sum;
                  ysum_d  = y_sum;
                  div_d   = total_count;
                  rem_d   = '0;
                  quot_d  = '0;
                  cnt_d   = '0;
                  state_d = (total_count == '0) ? DONE : DIV_X;
               end
            end
            DIV_X: begin
               rem_d  = rem_next;
               quot_d = quot_next;
               dvd_d  = dvd_q << 1;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  xq_d    = sat(quot_next);
                  dvd_d   = ysum_q;
                  rem_d   = '0;
                  quot_d  = '0;
                  cnt_d   = '0;
                  state_d = DIV_Y;
               end
            end
            DIV_Y: begin
               rem_d  = rem_next;
               quot_d = quot_next;
               dvd_d  = dvd_q << 1;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) state_d = DONE;
            end
            DONE: begin
               valid_d = 1'b1;
               state_d = IDLE;
               if (div_q == '0) begin
                  xpos_d  = '0;
                  ypos_d  = '0;
                  noobj_d = 1'b1;
               end else begin
                  xpos_d  = xq_q;
                  ypos_d  = sat(quot_q);
                  noobj_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         ysum_q  <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         cnt_q   <= '0;
         xq_q    <= '0;
         xpos_q  <= '0;
         ypos_q  <= '0;
         valid_q <= 1'b0;
         noobj_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         ysum_q  <= ysum_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         cnt_q   <= cnt_d;
         xq_q    <= xq_d;
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         valid_q <= valid_d;
         noobj_q <= noobj_d;
         ovr_q   <= ovr_d;
      end
   end

   assign x_position     = xpos_q;
   assign y_position     = ypos_q;
   assign valid_position = valid_q;
   assign no_object      = noobj_q;
   assign overrun        = ovr_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_measure_div_sched.sv
// tb/tb_measure_div_sched.sv - randomized and directed checks of measure_div_sched against a latency/arithmetic model
module tb_measure_div_sched;

   localparam int IW = 11;
   localparam int SW = 27;
   localparam int CW = 19;

   logic          clk = 1'b0;
   logic          aresetn = 1'b1;
   logic          enable = 1'b0;
   logic          frame_done = 1'b0;
   logic [SW-1:0] x_sum = '0;
   logic [SW-1:0] y_sum = '0;
   logic [CW-1:0] total_count = '0;
   logic [IW-1:0] x_position, y_position;
   logic          valid_position, no_object, busy, overrun;

   measure_div_sched #(.INPUT_WIDTH(IW), .SUM_WIDTH(SW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .aresetn(aresetn), .enable(enable), .frame_done(frame_done),
      .x_sum(x_sum), .y_sum(y_sum), .total_count(total_count),
      .x_position(x_position), .y_position(y_position), .valid_position(valid_position),
      .no_object(no_object), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;
   int strobe_cnt = 0;
   int strobe_edge = 0;
   int sx, sy, sno;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Model: an accepted frame produces its result a fixed number of edges later.
   logic m_valid, m_no, m_ovr, m_pend, m_pno;
   int   m_x, m_y, m_px, m_py, m_left;
   logic busy_before;

   function automatic int qsat(longint s, longint c);
      longint q;
      if (c == 0) return 0;
      q = s / c;
      return (q > 2047) ? 2047 : int'(q);
   endfunction

   always @(posedge clk or negedge aresetn) begin
      if (!aresetn || !enable) begin
         m_valid = 0; m_no = 0; m_ovr = 0; m_pend = 0; m_x = 0; m_y = 0; m_left = 0;
      end else begin
         busy_before = m_pend;
         m_valid = 0;
         if (m_pend) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_valid = 1; m_x = m_px; m_y = m_py; m_no = m_pno; m_pend = 0;
            end
         end
         if (frame_done) begin
            if (busy_before) m_ovr = 1;
            else begin
               m_pend = 1;
               m_pno  = (total_count == 0);
               m_left = (total_count == 0) ? 1 : 2 * SW + 1;
               m_px   = qsat(longint'(x_sum), longint'(total_count));
               m_py   = qsat(longint'(y_sum), longint'(total_count));
            end
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (valid_position !== m_valid || x_position !== IW'(m_x) || y_position !== IW'(m_y) ||
          no_object !== m_no || busy !== m_pend || overrun !== m_ovr) begin
         failures++;
         $display("FAIL cycle_compare edge=%0d actual v=%0b x=%0d y=%0d no=%0b busy=%0b ovr=%0b required v=%0b x=%0d y=%0d no=%0b busy=%0b ovr=%0b",
                  edge_cnt, valid_position, x_position, y_position, no_object, busy, overrun,
                  m_valid, m_x, m_y, m_no, m_pend, m_ovr);
      end
      if (valid_position === 1'b1) begin
         strobe_cnt++; strobe_edge = edge_cnt; sx = x_position; sy = y_position; sno = no_object;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic frame(input int xs, input int ys, input int cnt, output int n);
      @(negedge clk);
      x_sum = SW'(xs); y_sum = SW'(ys); total_count = CW'(cnt);
      frame_done = 1'b1;
      n = edge_cnt + 1;
      @(negedge clk);
      frame_done = 1'b0;
   endtask

   int n;

   initial begin
      #1 aresetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_x", int'(x_position), 0);
      chk("reset_valid", int'(valid_position), 0);
      chk("reset_busy", int'(busy), 0);
      #2 aresetn = 1'b1;
      enable = 1'b1;
      repeat (2) @(negedge clk);

      strobe_cnt = 0;
      frame(3200, 2400, 10, n);
      repeat (70) @(negedge clk);
      chk("basic_strobes", strobe_cnt, 1);
      chk("basic_latency", strobe_edge - n, 55);
      chk("basic_x", sx, 320);
      chk("basic_y", sy, 240);
      chk("basic_no_object", sno, 0);

      strobe_cnt = 0;
      frame(5, 5, 0, n);
      repeat (2) @(negedge clk);
      chk("zero_busy_n2", int'(busy), 0);
      repeat (5) @(negedge clk);
      chk("zero_latency", strobe_edge - n, 1);
      chk("zero_x", sx, 0);
      chk("zero_y", sy, 0);
      chk("zero_no_object", sno, 1);

      strobe_cnt = 0;
      frame(100000, 7, 1, n);
      repeat (60) @(negedge clk);
      chk("sat_x", sx, 2047);
      chk("sat_y", sy, 7);
      chk("sat_no_object", sno, 0);

      strobe_cnt = 0;
      frame(3200, 2400, 10, n);
      repeat (19) @(negedge clk);
      x_sum = SW'(9); y_sum = SW'(9); total_count = CW'(1); frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      chk("overrun_set", int'(overrun), 1);
      repeat (80) @(negedge clk);
      chk("overrun_strobes", strobe_cnt, 1);
      chk("overrun_latency", strobe_edge - n, 55);
      chk("overrun_x", sx, 320);
      chk("overrun_y", sy, 240);

      strobe_cnt = 0;
      frame(3200, 2400, 10, n);
      repeat (29) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_x", int'(x_position), 0);
      chk("abort_overrun", int'(overrun), 0);
      enable = 1'b1;
      repeat (60) @(negedge clk);
      chk("abort_no_strobe", strobe_cnt, 0);
      enable = 1'b0; frame_done = 1'b1; total_count = CW'(4);
      @(negedge clk);
      enable = 1'b1; frame_done = 1'b0;
      chk("disable_wins_busy", int'(busy), 0);
      repeat (60) @(negedge clk);
      chk("disable_wins_strobe", strobe_cnt, 0);

      frame(3200, 2400, 10, n);
      repeat (60) @(negedge clk);
      strobe_cnt = 0;
      frame(3200, 2400, 10, n);
      repeat (39) @(negedge clk);
      @(posedge clk);
      #2 aresetn = 1'b0;
      #1;
      chk("areset_x", int'(x_position), 0);
      chk("areset_y", int'(y_position), 0);
      chk("areset_busy", int'(busy), 0);
      @(negedge clk);
      #2 aresetn = 1'b1;
      repeat (70) @(negedge clk);
      chk("areset_no_strobe", strobe_cnt, 0);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         frame_done = ($urandom_range(0, 15) == 0);
         enable     = ($urandom_range(0, 299) != 0);
         x_sum      = SW'($urandom);
         y_sum      = SW'($urandom_range(0, 70000));
         case ($urandom_range(0, 3))
            0: total_count = '0;
            1: total_count = CW'($urandom_range(1, 15));
            2: total_count = CW'($urandom);
            default: total_count = CW'($urandom_range(1, 2000));
         endcase
         if ($urandom_range(0, 999) == 0) begin
            #1 aresetn = 1'b0;
            #2 aresetn = 1'b1;
         end
      end
      frame_done = 1'b0;
      repeat (60) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
